// File: rtl/uart_tx_fifo_param_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_param_pkg
// Description : Shared UART constants: parity modes, FSM state encodings and
//               a parity helper. Also used by the planned receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_fifo_param_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef logic [2:0] tx_state_t;

    localparam tx_state_t ST_IDLE   = 3'd0;
    localparam tx_state_t ST_START  = 3'd1;
    localparam tx_state_t ST_DATA   = 3'd2;
    localparam tx_state_t ST_PARITY = 3'd3;
    localparam tx_state_t ST_STOP   = 3'd4;

    // Bits above the configured data width must already be zero.
    function automatic logic parity_bit(input logic [7:0] bits, input int mode);
        return (mode == PARITY_ODD) ? ~^bits : ^bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_param_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word-fall-through FIFO with occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             w_push;
    logic             w_pop;

    // A full FIFO refuses a push even when a pop frees a slot on the same edge.
    assign w_push = push_i & ~full_o;
    assign w_pop  = pop_i & ~empty_o;

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == (AW + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_param
// Description : FIFO-buffered RS232 transmitter, LSB first, configurable frame.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo_param
    import uart_tx_fifo_param_pkg::*;
#(
    parameter  int CLK_DIVIDER = 3125,
    parameter  int DATA_BITS   = 8,
    parameter  int PARITY      = 0,
    parameter  int STOP_BITS   = 1,
    parameter  int FIFO_DEPTH  = 8,
    localparam int CW          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    data,
    input  logic          data_valid,
    output logic          data_ready,
    output logic          tx,
    output logic          busy,
    output logic          rts,
    output logic [CW-1:0] fifo_count
);

    tx_state_t            state_q, state_d;
    logic [15:0]          tick_q, tick_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [7:0]           shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 rts_q, rts_d;

    logic [DATA_BITS-1:0] w_fifo_rdata;
    logic [7:0]           w_head;
    logic                 w_full;
    logic                 w_empty;
    logic [CW-1:0]        w_count;
    logic [CW-1:0]        w_count_next;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_tick_end;
    logic                 w_unused;

    assign w_push     = data_valid & ~w_full;
    assign w_head     = 8'(w_fifo_rdata);
    assign w_tick_end = (tick_q == 16'(CLK_DIVIDER - 1));
    assign w_unused   = &{1'b0, data};

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .wdata_i (data[DATA_BITS-1:0]),
        .pop_i   (w_pop),
        .rdata_o (w_fifo_rdata),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tick_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            rts_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            rts_q     <= rts_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        w_pop     = 1'b0;

        if (state_q != ST_IDLE) begin
            tick_d = w_tick_end ? '0 : tick_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    state_d = ST_START;
                    tick_d  = '0;
                    shift_d = w_head;
                    par_d   = parity_bit(w_head, PARITY);
                end
            end
            ST_START: begin
                if (w_tick_end) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (w_tick_end) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick_end) begin
                    state_d   = ST_STOP;
                    bit_cnt_d = '0;
                end
            end
            ST_STOP: begin
                if (w_tick_end) begin
                    if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                        bit_cnt_d = '0;
                        // Chain straight into the next start bit when data is waiting.
                        if (!w_empty) begin
                            w_pop   = 1'b1;
                            state_d = ST_START;
                            shift_d = w_head;
                            par_d   = parity_bit(w_head, PARITY);
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
        w_count_next = w_count + CW'(w_push) - CW'(w_pop);
        busy_d       = (state_d != ST_IDLE) || (w_count_next != '0);
        rts_d        = ~busy_d;
    end

    assign data_ready = ~w_full;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign rts        = rts_q;
    assign fifo_count = w_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo_param
// Description : Four transmitter configurations (8N1, 8E1, 8O1, 7N2) checked
//               cycle by cycle against a frame-timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo_param;

    localparam int DIV   = 4;
    localparam int DEPTH = 8;
    localparam int NF    = 512;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din   [4];
    logic       vld   [4];
    logic       s_tx  [4];
    logic       s_bsy [4];
    logic       s_rts [4];
    logic       s_rdy [4];
    logic [3:0] s_cnt [4];

    always #5 clk = ~clk;

    uart_tx_fifo_param #(.CLK_DIVIDER(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u0 (
        .clk(clk), .rst(rst), .data(din[0]), .data_valid(vld[0]), .data_ready(s_rdy[0]),
        .tx(s_tx[0]), .busy(s_bsy[0]), .rts(s_rts[0]), .fifo_count(s_cnt[0]));
    uart_tx_fifo_param #(.CLK_DIVIDER(DIV), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u1 (
        .clk(clk), .rst(rst), .data(din[1]), .data_valid(vld[1]), .data_ready(s_rdy[1]),
        .tx(s_tx[1]), .busy(s_bsy[1]), .rts(s_rts[1]), .fifo_count(s_cnt[1]));
    uart_tx_fifo_param #(.CLK_DIVIDER(DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u2 (
        .clk(clk), .rst(rst), .data(din[2]), .data_valid(vld[2]), .data_ready(s_rdy[2]),
        .tx(s_tx[2]), .busy(s_bsy[2]), .rts(s_rts[2]), .fifo_count(s_cnt[2]));
    uart_tx_fifo_param #(.CLK_DIVIDER(DIV), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u3 (
        .clk(clk), .rst(rst), .data(din[3]), .data_valid(vld[3]), .data_ready(s_rdy[3]),
        .tx(s_tx[3]), .busy(s_bsy[3]), .rts(s_rts[3]), .fifo_count(s_cnt[3]));

    int cfg_db  [4] = '{8, 8, 8, 7};
    int cfg_par [4] = '{0, 1, 2, 0};
    int cfg_sb  [4] = '{1, 1, 1, 2};

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    int          nacc    [4];
    int          lastend [4];
    int          fst     [4][NF];
    logic [11:0] fbits   [4][NF];
    bit          accepted[4];

    // Each accepted byte becomes a frame that starts one edge after acceptance,
    // or the moment the previous frame ends, whichever is later.
    function automatic int flen(input int d);
        return 1 + cfg_db[d] + ((cfg_par[d] != 0) ? 1 : 0) + cfg_sb[d];
    endfunction

    function automatic logic [11:0] fcode(input int d, input logic [7:0] b);
        logic [11:0] f;
        int ones;
        int p;
        f    = '1;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < cfg_db[d]; i++) begin
            f[1+i] = b[i];
            ones  += int'(b[i]);
        end
        p = 1 + cfg_db[d];
        if (cfg_par[d] == 1) f[p] = (ones % 2 == 1);
        else if (cfg_par[d] == 2) f[p] = (ones % 2 == 0);
        return f;
    endfunction

    function automatic int m_count(input int d);
        int n;
        n = nacc[d];
        for (int k = 0; k < nacc[d]; k++) if (fst[d][k] <= cyc) n--;
        return n;
    endfunction

    function automatic int m_active(input int d);
        for (int k = 0; k < nacc[d]; k++)
            if (fst[d][k] <= cyc && cyc < fst[d][k] + flen(d) * DIV) return k;
        return -1;
    endfunction

    function automatic logic m_tx(input int d);
        int k;
        logic [11:0] f;
        k = m_active(d);
        if (k < 0) return 1'b1;
        f = fbits[d][k];
        return f[(cyc - fst[d][k]) / DIV];
    endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d cyc=%0d observed=%0h expected=%0h", tag, d, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        logic eb;
        for (int d = 0; d < 4; d++) begin
            eb = (m_count(d) > 0) || (m_active(d) >= 0);
            chk("tx",         d, 32'(s_tx[d]),  32'(m_tx(d)));
            chk("busy",       d, 32'(s_bsy[d]), 32'(eb));
            chk("rts",        d, 32'(s_rts[d]), 32'(!eb));
            chk("fifo_count", d, 32'(s_cnt[d]), 32'(m_count(d)));
            chk("data_ready", d, 32'(s_rdy[d]), 32'(m_count(d) < DEPTH));
        end
    endtask

    task automatic tick();
        bit pre [4];
        for (int d = 0; d < 4; d++) pre[d] = vld[d] && !rst && (m_count(d) < DEPTH);
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 4; d++) begin
            accepted[d] = 1'b0;
            if (rst) begin
                nacc[d]    = 0;
                lastend[d] = 0;
            end else if (pre[d]) begin
                int s;
                s = (cyc + 1 > lastend[d]) ? cyc + 1 : lastend[d];
                fst[d][nacc[d]]   = s;
                fbits[d][nacc[d]] = fcode(d, din[d]);
                lastend[d]        = s + flen(d) * DIV;
                nacc[d]++;
                accepted[d] = 1'b1;
            end
        end
        #1;
        check_all();
    endtask

    task automatic run_until(input int t);
        while (cyc < t) tick();
    endtask

    task automatic drain();
        int t;
        t = cyc;
        for (int d = 0; d < 4; d++) if (lastend[d] > t) t = lastend[d];
        run_until(t + 2);
    endtask

    task automatic push(input int d, input logic [7:0] b);
        int k;
        k = 0;
        din[d] = b;
        vld[d] = 1'b1;
        do begin
            tick();
            k++;
        end while (!accepted[d] && k < 200);
        vld[d] = 1'b0;
        chk("push_accept", d, 32'(accepted[d]), 32'd1);
    endtask

    initial begin
        logic [9:0] exp55;
        int e;
        int n;
        int k;
        int c41;
        bit saw_full;

        exp55 = 10'b1010101010;
        for (int d = 0; d < 4; d++) begin
            din[d] = 8'h00; vld[d] = 1'b0; nacc[d] = 0; lastend[d] = 0; accepted[d] = 1'b0;
        end

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_tx",    0, 32'(s_tx[0]),  32'd1);
        chk("rst_busy",  0, 32'(s_bsy[0]), 32'd0);
        chk("rst_rts",   0, 32'(s_rts[0]), 32'd1);
        chk("rst_ready", 0, 32'(s_rdy[0]), 32'd1);
        chk("rst_count", 0, 32'(s_cnt[0]), 32'd0);
        tick();

        // 8N1 frame of 0x55
        push(0, 8'h55);
        e = cyc;
        for (int i = 0; i < 10; i++) begin
            run_until(e + 1 + 4 * i + 2);
            chk("t1_bit",  0, 32'(s_tx[0]),  32'(exp55[i]));
            chk("t1_busy", 0, 32'(s_bsy[0]), 32'd1);
        end
        run_until(e + 40);
        chk("t1_busy_last", 0, 32'(s_bsy[0]), 32'd1);
        tick();
        chk("t1_busy_done", 0, 32'(s_bsy[0]), 32'd0);
        drain();

        // Even and odd parity of 0x07
        din[1] = 8'h07; din[2] = 8'h07; vld[1] = 1'b1; vld[2] = 1'b1;
        tick();
        vld[1] = 1'b0; vld[2] = 1'b0;
        chk("t2_acc_even", 1, 32'(accepted[1]), 32'd1);
        chk("t2_acc_odd",  2, 32'(accepted[2]), 32'd1);
        e = cyc;
        run_until(e + 39);
        chk("t2_par_even", 1, 32'(s_tx[1]), 32'd1);
        chk("t2_par_odd",  2, 32'(s_tx[2]), 32'd0);
        run_until(e + 44);
        chk("t2_busy_44", 1, 32'(s_bsy[1]), 32'd1);
        tick();
        chk("t2_idle_45", 1, 32'(s_bsy[1]), 32'd0);
        chk("t2_idle_45", 2, 32'(s_bsy[2]), 32'd0);
        drain();

        // 7N2 back-to-back 0xFF frames
        din[3] = 8'hFF; vld[3] = 1'b1;
        tick();
        e = cyc;
        tick();
        vld[3] = 1'b0;
        run_until(e + 34);
        chk("t3_stop1", 3, 32'(s_tx[3]), 32'd1);
        run_until(e + 40);
        chk("t3_stop2", 3, 32'(s_tx[3]), 32'd1);
        tick();
        chk("t3_next_start", 3, 32'(s_tx[3]), 32'd0);
        drain();

        // Hold data_valid for 10 bytes into a depth-8 FIFO
        n = 0; k = 0; e = 0; c41 = -1; saw_full = 1'b0;
        din[0] = 8'($urandom); vld[0] = 1'b1;
        while (n < 10 && k < 400) begin
            tick();
            k++;
            if (s_cnt[0] == 4'd8 && s_rdy[0] == 1'b0) saw_full = 1'b1;
            if (n > 0 && cyc == e + 41) c41 = int'(s_cnt[0]);
            if (accepted[0]) begin
                if (n == 0) e = cyc;
                n++;
                din[0] = 8'($urandom);
            end
        end
        vld[0] = 1'b0;
        chk("t4_bytes",     0, 32'(n),        32'd10);
        chk("t4_full_seen", 0, 32'(saw_full), 32'd1);
        chk("t4_pop_full",  0, 32'(c41),      32'd7);
        drain();

        // Reset during data bit 3
        push(0, 8'($urandom));
        e = cyc;
        run_until(e + 18);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_tx",    0, 32'(s_tx[0]),  32'd1);
        chk("t5_count", 0, 32'(s_cnt[0]), 32'd0);
        chk("t5_rts",   0, 32'(s_rts[0]), 32'd1);
        push(0, 8'hA3);
        drain();

        // Push and pop on the same edge at count 3
        n = 0; k = 0; e = 0;
        vld[0] = 1'b1;
        while (n < 4 && k < 50) begin
            din[0] = 8'($urandom);
            tick();
            k++;
            if (accepted[0]) begin
                if (n == 0) e = cyc;
                n++;
            end
        end
        vld[0] = 1'b0;
        run_until(e + 40);
        chk("t6_count_before", 0, 32'(s_cnt[0]), 32'd3);
        din[0] = 8'($urandom); vld[0] = 1'b1;
        tick();
        vld[0] = 1'b0;
        chk("t6_accepted", 0, 32'(accepted[0]), 32'd1);
        chk("t6_pushpop",  0, 32'(s_cnt[0]),    32'd3);
        drain();

        // Random traffic on all four configurations
        for (int c = 0; c < 1500; c++) begin
            for (int d = 0; d < 4; d++) begin
                if (!vld[d] && $urandom_range(0, 15) == 0) begin
                    vld[d] = 1'b1;
                    din[d] = 8'($urandom);
                end
            end
            tick();
            for (int d = 0; d < 4; d++) begin
                if (accepted[d]) begin
                    if ($urandom_range(0, 2) == 0) din[d] = 8'($urandom);
                    else vld[d] = 1'b0;
                end
            end
        end
        for (int d = 0; d < 4; d++) vld[d] = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
